// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    RESP   = 3'd4
  } lsu_state_e;

  // Request fields kept for the duration of an access.
  typedef struct packed {
    logic [1:0]      size;
    logic            sext;
    logic [1:0]      offset;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  // Right-justified lane mask for an access size; illegal size behaves as a full word.
  function automatic logic [XLEN-1:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_mask = XLEN'(32'h0000_00ff);
      SIZE_HALF: size_mask = XLEN'(32'h0000_ffff);
      default:   size_mask = '1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response and data-memory port bundle of the load/store unit.
interface lsu_if;
  import lsu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_sext;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  // Pipeline plus memory side.
  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extract/extend load data and merge sub-word store data into a word.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      size,
  input  logic [1:0]      offset,
  input  logic            sext,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_c,
  output logic [XLEN-1:0] merge_c
);

  logic [1:0]      lane_idx;
  logic [4:0]      shamt;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] lane;
  logic            sign;

  always_comb begin
    lane_idx = 2'd0;
    case (size)
      SIZE_BYTE: lane_idx = BIG_ENDIAN ? 2'(2'd3 - offset) : offset;
      SIZE_HALF: lane_idx = BIG_ENDIAN ? 2'(2'd2 - {offset[1], 1'b0}) : {offset[1], 1'b0};
      default:   lane_idx = 2'd0;
    endcase
    shamt = {lane_idx, 3'b000};
    mask  = size_mask(size);
    lane  = (word >> shamt) & mask;
    sign  = (size == SIZE_BYTE) ? lane[7] : lane[15];

    load_c = lane;
    if (sext && (size == SIZE_BYTE || size == SIZE_HALF) && sign) begin
      load_c = lane | ~mask;
    end

    // Only the addressed lane is replaced; every other byte is carried through.
    merge_c = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end: checks requests, sequences word-wide memory
// accesses (read-modify-write for sub-word stores) and stalls the pipeline meanwhile.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 50,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  localparam logic [XLEN-3:0] WORD_LIMIT = (XLEN-2)'(MEM_WORDS);

  lsu_state_e      state, state_n;
  lsu_req_t        req_q, req_n, req_in_c;
  logic            req_bad_c;

  logic            ready_q, ready_n;
  logic            resp_valid_q, resp_valid_n;
  logic            resp_err_q, resp_err_n;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_n;
  logic            mem_read_q, mem_read_n;
  logic            mem_write_q, mem_write_n;
  logic [XLEN-1:0] mem_addr_q, mem_addr_n;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_n;

  logic [XLEN-1:0] load_c;
  logic [XLEN-1:0] merge_c;

  lsu_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .word    (bus.mem_rdata),
    .size    (req_q.size),
    .offset  (req_q.offset),
    .sext    (req_q.sext),
    .wdata   (req_q.wdata),
    .load_c  (load_c),
    .merge_c (merge_c)
  );

  // Incoming request fields and the accept-time legality check.
  always_comb begin
    req_in_c.size   = bus.req_size;
    req_in_c.sext   = bus.req_sext;
    req_in_c.offset = bus.req_addr[1:0];
    req_in_c.wdata  = bus.req_wdata;

    req_bad_c = (bus.req_size == SIZE_ILL)
             || (bus.req_size == SIZE_HALF && bus.req_addr[0])
             || (bus.req_size == SIZE_WORD && bus.req_addr[1:0] != 2'b00)
             || (bus.req_addr[XLEN-1:2] >= WORD_LIMIT);
  end

  // Next-state and next-output logic; memory address/data only move while mem_write is low or rising.
  always_comb begin
    state_n      = state;
    req_n        = req_q;
    resp_valid_n = 1'b0;
    resp_err_n   = 1'b0;
    resp_rdata_n = '0;
    mem_read_n   = 1'b0;
    mem_write_n  = 1'b0;
    mem_addr_n   = mem_addr_q;
    mem_wdata_n  = mem_wdata_q;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_bad_c) begin
            resp_err_n = 1'b1;
          end else begin
            req_n      = req_in_c;
            mem_addr_n = XLEN'(bus.req_addr[XLEN-1:2]);
            if (!bus.req_we) begin
              state_n    = LD;
              mem_read_n = 1'b1;
            end else if (bus.req_size == SIZE_WORD) begin
              state_n     = WR;
              mem_write_n = 1'b1;
              mem_wdata_n = bus.req_wdata;
            end else begin
              state_n    = RMW_RD;
              mem_read_n = 1'b1;
            end
          end
        end
      end
      LD: begin
        state_n      = RESP;
        resp_valid_n = 1'b1;
        resp_rdata_n = load_c;
      end
      RMW_RD: begin
        state_n     = WR;
        mem_write_n = 1'b1;
        mem_wdata_n = merge_c;
      end
      WR: begin
        state_n      = RESP;
        resp_valid_n = 1'b1;
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_q        <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state        <= state_n;
      req_q        <= req_n;
      ready_q      <= ready_n;
      resp_valid_q <= resp_valid_n;
      resp_err_q   <= resp_err_n;
      resp_rdata_q <= resp_rdata_n;
      mem_read_q   <= mem_read_n;
      mem_write_q  <= mem_write_n;
      mem_addr_q   <= mem_addr_n;
      mem_wdata_q  <= mem_wdata_n;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-addressed big-endian reference memory,
// directed scenarios plus randomized traffic, and a reset-during-write check.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned MEM_WORDS = 50;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lsu_if bus();

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .BIG_ENDIAN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  // Level-sensitive data memory, sampled once per cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_write && bus.mem_addr < 32'(MEM_WORDS))
      mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
  end

  assign bus.mem_rdata = (bus.mem_read && bus.mem_addr < 32'(MEM_WORDS)) ? mem[bus.mem_addr[5:0]] : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference memory viewed as bytes; byte 0 of a word is its most significant byte.
  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[int'(a >> 2)];
    case (a[1:0])
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  function automatic void wr_byte(input logic [31:0] a, input logic [7:0] b);
    int idx;
    idx = int'(a >> 2);
    case (a[1:0])
      2'd0:    ref_mem[idx][31:24] = b;
      2'd1:    ref_mem[idx][23:16] = b;
      2'd2:    ref_mem[idx][15:8]  = b;
      default: ref_mem[idx][7:0]   = b;
    endcase
  endfunction

  function automatic bit is_bad(input logic [1:0] size, input logic [31:0] a);
    int n;
    if (size == 2'b11) return 1'b1;
    n = 1 << size;
    if ((a % n) != 0) return 1'b1;
    return (a >> 2) >= MEM_WORDS;
  endfunction

  // Applies one operation to the reference memory and returns its expected response and latency.
  task automatic model_op(input bit we, input logic [1:0] size, input bit sext,
                          input logic [31:0] a, input logic [31:0] wdata,
                          output exp_t e, output int lat);
    int n;
    logic [31:0] v;
    e.err = 1'b0; e.rdata = 32'h0; e.cyc = 0;
    if (is_bad(size, a)) begin
      e.err = 1'b1;
      lat   = 1;
      return;
    end
    n = 1 << size;
    if (!we) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(rd_byte(a + 32'(i)));
      if (sext && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      e.rdata = v;
      lat     = 2;
    end else begin
      for (int i = 0; i < n; i++) begin
        v = wdata >> (8*(n-1-i));
        wr_byte(a + 32'(i), v[7:0]);
      end
      lat = (n == 4) ? 2 : 3;
    end
  endtask

  // Monitor: scoreboard pops and memory-port protocol checks.
  bit          prev_we = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  int          wr_run = 0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we = 1'b0;
      wr_run  = 0;
    end else begin
      chk("rd_wr_exclusive", 32'(bus.mem_read & bus.mem_write), 32'h0);
      if (prev_we) begin
        chk("mem_addr_hold", bus.mem_addr, prev_addr);
        chk("mem_wdata_hold", bus.mem_wdata, prev_wdata);
      end
      if (bus.mem_write) wr_run++;
      else begin
        if (wr_run != 0) chk("mem_write_width", 32'(wr_run), 32'h1);
        wr_run = 0;
      end
      prev_we    = bus.mem_write;
      prev_addr  = bus.mem_addr;
      prev_wdata = bus.mem_wdata;

      if (bus.resp_valid || bus.resp_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", {30'h0, bus.resp_valid, bus.resp_err}, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_err", 32'(bus.resp_err), 32'(mon_e.err));
          chk("resp_valid", 32'(bus.resp_valid), 32'(!mon_e.err));
          chk("resp_rdata", bus.resp_rdata, mon_e.rdata);
          chk("resp_latency", cyc, mon_e.cyc);
        end
      end
    end
  end

  // Issues one op (called on a negedge) and returns on the negedge where req_ready is back.
  task automatic do_op(input bit we, input logic [1:0] size, input bit sext,
                       input logic [31:0] a, input logic [31:0] wdata, input bit hold);
    exp_t e;
    int   lat, w, st;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_sext  = sext;
    bus.req_addr  = a;
    bus.req_wdata = wdata;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) begin
      chk("accept_timeout", 32'(bus.req_ready), 32'h1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model_op(we, size, sext, a, wdata, e, lat);
    e.cyc = cyc + 32'(lat) - 1;
    exp_q.push_back(e);
    @(negedge clk);
    if (e.err) begin
      chk("err_no_mem", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    end else begin
      chk("mem_addr", bus.mem_addr, a >> 2);
      chk("mem_read_start", 32'(bus.mem_read), 32'(!we || size != SIZE_WORD));
      chk("mem_write_start", 32'(bus.mem_write), 32'(we && size == SIZE_WORD));
    end
    st = 0;
    while (!bus.req_ready && st < 20) begin
      if (hold) begin
        bus.req_we    = 1'($urandom);
        bus.req_size  = 2'($urandom);
        bus.req_sext  = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
      end
      st++;
      @(negedge clk);
    end
    chk("stall_cycles", 32'(st), e.err ? 32'h0 : 32'(lat));
    if (!hold) bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] a, wd;
    logic [1:0]  sz;
    bit          we, hold;

    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_sext  = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'h0);
    chk("rst_mem_ctrl", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store then load.
    do_op(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    do_op(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b0);
    // Byte merge; upper wdata bits must be ignored.
    do_op(1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h1122_3344, 1'b0);
    do_op(1'b1, SIZE_BYTE, 1'b0, 32'h21, 32'h5555_55AA, 1'b0);
    do_op(1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0, 1'b0);
    // Sign/zero extension.
    do_op(1'b1, SIZE_WORD, 1'b0, 32'h30, 32'h80FF_7F01, 1'b0);
    do_op(1'b0, SIZE_BYTE, 1'b1, 32'h30, 32'h0, 1'b0);
    do_op(1'b0, SIZE_BYTE, 1'b0, 32'h30, 32'h0, 1'b0);
    do_op(1'b0, SIZE_HALF, 1'b1, 32'h32, 32'h0, 1'b0);
    do_op(1'b0, SIZE_HALF, 1'b1, 32'h30, 32'h0, 1'b0);
    do_op(1'b1, SIZE_HALF, 1'b0, 32'h32, 32'hAAAA_8123, 1'b0);
    do_op(1'b0, SIZE_WORD, 1'b0, 32'h30, 32'h0, 1'b0);
    // Error cases.
    do_op(1'b0, SIZE_WORD, 1'b0, 32'h06, 32'h0, 1'b0);
    do_op(1'b1, SIZE_HALF, 1'b0, 32'h03, 32'h1234, 1'b0);
    do_op(1'b0, SIZE_ILL, 1'b0, 32'h00, 32'h0, 1'b0);
    do_op(1'b0, SIZE_WORD, 1'b0, 32'hC8, 32'h0, 1'b0);
    do_op(1'b1, SIZE_WORD, 1'b0, 32'hC8, 32'h0BAD_0BAD, 1'b0);
    do_op(1'b0, SIZE_WORD, 1'b0, 32'hC4, 32'h0, 1'b0);
    // Back-to-back with req_valid held and fields churned during stalls.
    do_op(1'b1, SIZE_HALF, 1'b0, 32'h40, 32'hFFFF_BEEF, 1'b1);
    do_op(1'b1, SIZE_WORD, 1'b0, 32'h44, 32'hCAFE_F00D, 1'b1);
    do_op(1'b1, SIZE_BYTE, 1'b0, 32'h43, 32'h0000_0077, 1'b1);
    do_op(1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, 1'b1);
    do_op(1'b0, SIZE_BYTE, 1'b1, 32'h45, 32'h0, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 150; k++) begin
      we   = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      a    = {24'h0, 6'($urandom_range(0, 53)), 2'($urandom)};
      if (k % 25 == 0) a = $urandom;
      wd   = $urandom;
      hold = (k != 149) && ($urandom_range(0, 1) == 1);
      do_op(we, sz, 1'($urandom), a, wd, hold);
    end

    // Reset while the write half of a read-modify-write is on the memory port.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = SIZE_BYTE;
    bus.req_sext  = 1'b0;
    bus.req_addr  = 32'h4A;
    bus.req_wdata = 32'h0000_00C3;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_read_phase", 32'(bus.mem_read), 32'h1);
    @(negedge clk);
    chk("rmw_write_phase", 32'(bus.mem_write), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_drops_write", 32'(bus.mem_write), 32'h0);
    chk("reset_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1'b0, SIZE_WORD, 1'b0, 32'h48, 32'h0, 1'b0);
    do_op(1'b1, SIZE_BYTE, 1'b0, 32'h4A, 32'h0000_00C3, 1'b0);
    do_op(1'b0, SIZE_WORD, 1'b0, 32'h48, 32'h0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
